race_controller: RTL and testbench

//   Drives the race PUF from the arbiter's upstream side. Per response bit it:
//   - applies a challenge;
//   - clears the race_arbiter via its rst input;
//   - launches the race;
//   - waits for the arbiter's done flag, then captures its out bit.

---
 rtl/race_controller.sv | 211 +++++++++++++++++++++
 tb/tb_race_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// race_controller
//   Upstream driver for a race PUF. For every response bit it applies a
//   challenge, clears the race_arbiter, launches the race, waits for the
//   arbiter's done flag (through a 2-flop synchronizer) and captures the
//   arbiter's out bit. RESP_BITS captured bits form one response word,
//   reported with a one-cycle resp_valid pulse.
//
//   Ports
//     clk            in   system clock
//     global_rst     in   synchronous active-high reset
//     start          in   one-cycle request, honoured only in IDLE
//     challenge_seed in   base challenge, latched on an accepted start
//     busy           out  request in progress (CLEAR/RACE/CAPTURE)
//     challenge      out  seed + bit index, applied to the PUF paths
//     race_en        out  launches the race, high throughout RACE
//     arb_rst        out  race_arbiter clear, high in every state but RACE
//     arb_done       in   arbiter done, asynchronous to clk
//     arb_out        in   arbiter result, asynchronous to clk
//     response       out  assembled response word (LSB = first race)
//     resp_valid     out  one-cycle pulse in the DONE state
//     timeout_err    out  sticky per request: a race timed out
//
//   Build option
//     MAJORITY_VOTE_EN  when defined, each bit is raced three times with the
//                       same challenge and the majority result is stored.
module race_controller #(
  parameter int RESP_BITS = 8,
  parameter int CHAL_W    = 8,
  parameter int SETTLE    = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 global_rst,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge_seed,
  output logic                 busy,
  output logic [CHAL_W-1:0]    challenge,
  output logic                 race_en,
  output logic                 arb_rst,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  output logic                 timeout_err
);

  localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RACE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CHAL_W-1:0]      seed_q, seed_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic                   terr_q, terr_d;
  logic                   bit_q, bit_d;
  logic                   done_s1_q, done_s2_q;
  logic                   out_s1_q, out_s2_q;
`ifdef MAJORITY_VOTE_EN
  logic [1:0]             trial_q, trial_d;
  logic [1:0]             votes_q, votes_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // Synchronizers, state and datapath registers
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q   <= S_IDLE;
      seed_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      terr_q    <= 1'b0;
      bit_q     <= 1'b0;
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      out_s1_q  <= 1'b0;
      out_s2_q  <= 1'b0;
`ifdef MAJORITY_VOTE_EN
      trial_q   <= '0;
      votes_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      terr_q    <= terr_d;
      bit_q     <= bit_d;
      done_s1_q <= arb_done;
      done_s2_q <= done_s1_q;
      out_s1_q  <= arb_out;
      out_s2_q  <= out_s1_q;
`ifdef MAJORITY_VOTE_EN
      trial_q   <= trial_d;
      votes_q   <= votes_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    terr_d  = terr_q;
    bit_d   = bit_q;
`ifdef MAJORITY_VOTE_EN
    trial_d = trial_q;
    votes_d = votes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          seed_d  = challenge_seed;
          idx_d   = '0;
          cnt_d   = '0;
          resp_d  = '0;
          terr_d  = 1'b0;
`ifdef MAJORITY_VOTE_EN
          trial_d = '0;
`endif
        end
      end
      S_CLEAR: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_RACE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RACE: begin
        // The first two RACE cycles may still show a done left over from the
        // previous race travelling through the synchronizer, so skip them.
        // A genuine done beats a simultaneous timeout.
        if (cnt_q >= CNT_W'(2) && done_s2_q) begin
          bit_d   = out_s2_q;
          state_d = S_CAPTURE;
        end else if (cnt_q == TO_LAST) begin
          bit_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        cnt_d = '0;
`ifdef MAJORITY_VOTE_EN
        if (trial_q != 2'd2) begin
          votes_d[trial_q[0]] = bit_q;
          trial_d             = trial_q + 2'd1;
          state_d             = S_CLEAR;
        end else begin
          trial_d        = '0;
          resp_d[idx_q]  = maj3(votes_q[0], votes_q[1], bit_q);
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_CLEAR;
          end
        end
`else
        resp_d[idx_q] = bit_q;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_CLEAR;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_CLEAR) || (state_q == S_RACE) || (state_q == S_CAPTURE);
  assign race_en     = (state_q == S_RACE);
  assign arb_rst     = (state_q != S_RACE);
  assign resp_valid  = (state_q == S_DONE);
  assign challenge   = seed_q + CHAL_W'(idx_q);
  assign response    = resp_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_race_controller.sv
module tb_race_controller;

  localparam int RB = 8;
  localparam int CW = 8;
  localparam int ST = 4;
  localparam int TO = 40;
`ifdef MAJORITY_VOTE_EN
  localparam int TRIALS = 3;
`else
  localparam int TRIALS = 1;
`endif

  logic          clk = 1'b0;
  logic          global_rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] challenge_seed = '0;
  logic          busy;
  logic [CW-1:0] challenge;
  logic          race_en;
  logic          arb_rst;
  logic          arb_done = 1'b0;
  logic          arb_out = 1'b0;
  logic [RB-1:0] response;
  logic          resp_valid;
  logic          timeout_err;

  always #5 clk = ~clk;

  race_controller #(.RESP_BITS(RB), .CHAL_W(CW), .SETTLE(ST), .TIMEOUT(TO)) dut (
    .clk(clk), .global_rst(global_rst), .start(start), .challenge_seed(challenge_seed),
    .busy(busy), .challenge(challenge), .race_en(race_en), .arb_rst(arb_rst),
    .arb_done(arb_done), .arb_out(arb_out), .response(response),
    .resp_valid(resp_valid), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  logic [RB:0]   exp_q[$];   // {timeout_err, response}
  logic [CW-1:0] chal_q[$];  // challenge expected at each race launch

  int   mode = 0;        // 0: out=chal[0], 1: out=chal[1], 2: vote pattern
  int   hang_chal = -1;  // challenge for which the arbiter never finishes
  int   race_num = 0;
  int   race_len = 0;
  int   m_cnt = 0;
  logic prev_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_bit();
    int trial;
    int bidx;
    case (mode)
      0: return challenge[0];
      1: return challenge[1];
      default: begin
        trial = (race_num - 1) % 3;
        bidx  = (race_num - 1) / 3;
        // even bits vote 1,0,1 -> 1 ; odd bits vote 0,0,1 -> 0
        if (bidx % 2 == 0) return (trial != 1);
        else               return (trial == 2);
      end
    endcase
  endfunction

  // Arbiter model plus race-launch monitor
  always @(negedge clk) begin
    logic [CW-1:0] e;
    if (race_en && !prev_en) begin
      race_num++;
      race_len = 0;
      if (chal_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_race: got challenge %0h, expected no race", challenge);
      end else begin
        e = chal_q.pop_front();
        chk("challenge", 32'(challenge), 32'(e));
      end
    end
    if (race_en) race_len++;
    if (!race_en && prev_en && int'(challenge) == hang_chal)
      chk("timeout_len", 32'(race_len), 32'(TO));
    prev_en = race_en;

    if (arb_rst) begin
      m_cnt    = 0;
      arb_done = 1'b0;
      arb_out  = 1'b0;
    end else if (race_en) begin
      if (m_cnt == 1 + (race_num % 3) && int'(challenge) != hang_chal) begin
        arb_done = 1'b1;
        arb_out  = model_bit();
      end
      m_cnt++;
    end
  end

  // Response scoreboard monitor
  always @(negedge clk) begin
    logic [RB:0] e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got response %0h, expected no pulse", response);
      end else begin
        e = exp_q.pop_front();
        chk("response", 32'(response), 32'(e[RB-1:0]));
        chk("timeout_err", 32'(timeout_err), 32'(e[RB]));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic expect_req(input logic [CW-1:0] seed, input logic [RB-1:0] resp, input logic terr);
    exp_q.push_back({terr, resp});
    for (int i = 0; i < RB; i++)
      for (int t = 0; t < TRIALS; t++)
        chal_q.push_back(seed + CW'(i));
  endtask

  task automatic pulse_start(input logic [CW-1:0] seed);
    @(negedge clk);
    start = 1'b1;
    challenge_seed = seed;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (resp_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL resp_valid_timeout: got no pulse, expected one within %0d cycles", budget);
  endtask

  task automatic run_req(input logic [CW-1:0] seed, input logic [RB-1:0] resp, input logic terr);
    race_num = 0;
    expect_req(seed, resp, terr);
    pulse_start(seed);
    wait_valid(6000);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_race_en"}, 32'(race_en), 32'd0);
    chk({tag, "_arb_rst"}, 32'(arb_rst), 32'd1);
    chk({tag, "_challenge"}, 32'(challenge), 32'd0);
    chk({tag, "_response"}, 32'(response), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    bit seen;
    // Reset, with start held high throughout
    global_rst = 1'b1;
    start = 1'b1;
    challenge_seed = 8'hAB;
    repeat (3) @(negedge clk);
    global_rst = 1'b0;
    start = 1'b0;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    chk("idle_after_reset_busy", 32'(busy), 32'd0);

    // Alternating bits
    mode = 0;
    run_req(8'hF0, 8'hAA, 1'b0);

    // Arbiter hangs on the fourth race
    hang_chal = 8'h13;
    run_req(8'h10, 8'hA2, 1'b1);
    hang_chal = -1;

    // Starts while busy and in the DONE cycle are ignored
    race_num = 0;
    expect_req(8'h21, 8'h55, 1'b0);
    pulse_start(8'h21);
    repeat (20) @(negedge clk);
    chk("busy_mid_request", 32'(busy), 32'd1);
    pulse_start(8'h99);
    wait_valid(6000);
    start = 1'b1;
    challenge_seed = 8'h77;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done_start", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    chk("busy_still_idle", 32'(busy), 32'd0);
    chk("response_stable", 32'(response), 32'h55);

    // Reset in the middle of a race, then a fresh request
    race_num = 0;
    expect_req(8'h30, 8'h00, 1'b0);
    pulse_start(8'h30);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (race_num == 6 && race_en) seen = 1'b1;
    end
    chk("reached_race5", 32'(seen), 32'd1);
    global_rst = 1'b1;
    @(negedge clk);
    global_rst = 1'b0;
    exp_q.delete();
    chal_q.delete();
    check_reset_outputs("midrace_reset");
    mode = 1;
    run_req(8'h00, 8'hCC, 1'b0);

`ifdef MAJORITY_VOTE_EN
    mode = 2;
    run_req(8'h40, 8'h55, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("chal_queue_empty", 32'(chal_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
